// File: rtl/writeback_queue.sv
// Writeback queue: a circular FIFO of pending register-file writes. It drains
// one entry per cycle to the RF write port and can forward pending values.
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   wb_valid/wb_ready          producer handshake, wb_reg/wb_data payload
//   rf_stall                   RF write port busy
//   rf_we/rf_reg/rf_data       head entry offered to the RF
//   lookup_reg1/2              read indices to check for pending writes
//   hit1/2, fwd_data1/2        match flag and youngest pending value
//   count                      occupied entries
module writeback_queue #(
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     wb_valid,
   output logic                     wb_ready,
   input  logic [4:0]               wb_reg,
   input  logic [31:0]              wb_data,
   input  logic                     rf_stall,
   output logic                     rf_we,
   output logic [4:0]               rf_reg,
   output logic [31:0]              rf_data,
   input  logic [4:0]               lookup_reg1,
   input  logic [4:0]               lookup_reg2,
   output logic                     hit1,
   output logic                     hit2,
   output logic [31:0]              fwd_data1,
   output logic [31:0]              fwd_data2,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [4:0]    r_reg  [DEPTH];
   logic [31:0]   r_data [DEPTH];
   logic [AW-1:0] r_wptr;
   logic [AW-1:0] r_rptr;
   logic [CW-1:0] r_count;

   logic          w_full;
   logic          w_empty;
   logic          w_accept;
   logic          w_push;
   logic          w_pop;
   logic [AW-1:0] w_idx;

   assign count    = r_count;
   assign w_full   = (r_count == CW'(DEPTH));
   assign w_empty  = (r_count == '0);

   // A slot freed by this cycle's pop is not reusable until next cycle.
   assign wb_ready = rst_n && !w_full;
   assign w_accept = wb_valid && wb_ready;

   // Writes to x0 complete the handshake but are never stored.
   assign w_push   = w_accept && (wb_reg != 5'd0);

   assign rf_we    = !w_empty && !rf_stall;
   assign w_pop    = rf_we;
   assign rf_reg   = w_empty ? 5'd0  : r_reg[r_rptr];
   assign rf_data  = w_empty ? 32'd0 : r_data[r_rptr];

   // DEPTH is a power of two, so pointers wrap by natural overflow.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else begin
         if (w_push) r_wptr <= r_wptr + 1'b1;
         if (w_pop)  r_rptr <= r_rptr + 1'b1;
         unique case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (w_push) begin
         r_reg[r_wptr]  <= wb_reg;
         r_data[r_wptr] <= wb_data;
      end
   end

   // Walk from oldest to youngest so the last match is the youngest value.
   always_comb begin
      hit1      = 1'b0;
      hit2      = 1'b0;
      fwd_data1 = 32'd0;
      fwd_data2 = 32'd0;
      w_idx     = '0;
      for (int i = 0; i < DEPTH; i++) begin
         w_idx = r_rptr + AW'(i);
         if (CW'(i) < r_count) begin
            if (lookup_reg1 != 5'd0 && r_reg[w_idx] == lookup_reg1) begin
               hit1      = 1'b1;
               fwd_data1 = r_data[w_idx];
            end
            if (lookup_reg2 != 5'd0 && r_reg[w_idx] == lookup_reg2) begin
               hit2      = 1'b1;
               fwd_data2 = r_data[w_idx];
            end
         end
      end
   end

endmodule

// File: tb/tb_writeback_queue.sv
// Testbench for writeback_queue: directed scenarios plus random traffic,
// checked against a queue-based reference model and an output scoreboard.
module tb_writeback_queue;

   localparam int DEPTH = 4;

   typedef struct {
      logic [4:0]  r;
      logic [31:0] d;
   } ent_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        wb_valid;
   logic        wb_ready;
   logic [4:0]  wb_reg;
   logic [31:0] wb_data;
   logic        rf_stall;
   logic        rf_we;
   logic [4:0]  rf_reg;
   logic [31:0] rf_data;
   logic [4:0]  lookup_reg1;
   logic [4:0]  lookup_reg2;
   logic        hit1;
   logic        hit2;
   logic [31:0] fwd_data1;
   logic [31:0] fwd_data2;
   logic [2:0]  count;

   int n_chk  = 0;
   int n_pass = 0;

   ent_t mq[$];
   ent_t sb[$];

   writeback_queue #(.DEPTH(DEPTH)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .wb_valid    (wb_valid),
      .wb_ready    (wb_ready),
      .wb_reg      (wb_reg),
      .wb_data     (wb_data),
      .rf_stall    (rf_stall),
      .rf_we       (rf_we),
      .rf_reg      (rf_reg),
      .rf_data     (rf_data),
      .lookup_reg1 (lookup_reg1),
      .lookup_reg2 (lookup_reg2),
      .hit1        (hit1),
      .hit2        (hit2),
      .fwd_data1   (fwd_data1),
      .fwd_data2   (fwd_data2),
      .count       (count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h want %0h", nm, act, exp);
   endtask

   // Youngest pending value for a key: {hit, data}.
   function automatic logic [32:0] m_look(input logic [4:0] k);
      logic [32:0] res;
      res = '0;
      if (k != 5'd0)
         foreach (mq[i])
            if (mq[i].r == k) res = {1'b1, mq[i].d};
      return res;
   endfunction

   // Advance the model across the coming rising edge.
   task automatic model_step();
      logic acc;
      logic drn;
      ent_t e;
      acc = rst_n && wb_valid && (mq.size() < DEPTH);
      drn = rst_n && (mq.size() > 0) && !rf_stall;
      if (drn) void'(mq.pop_front());
      if (acc && wb_reg != 5'd0) begin
         e.r = wb_reg;
         e.d = wb_data;
         mq.push_back(e);
         sb.push_back(e);
      end
   endtask

   always @(negedge clk) begin : mon
      logic [32:0] l1;
      logic [32:0] l2;
      logic        exp_we;
      ent_t        hd;
      ent_t        e;
      exp_we = rst_n && (mq.size() > 0) && !rf_stall;
      hd.r = 5'd0;
      hd.d = 32'd0;
      if (mq.size() > 0) hd = mq[0];
      l1 = m_look(lookup_reg1);
      l2 = m_look(lookup_reg2);
      chk("count", 32'(count), 32'(mq.size()));
      chk("wb_ready", 32'(wb_ready),
          32'(rst_n && (mq.size() < DEPTH)));
      chk("rf_we", 32'(rf_we), 32'(exp_we));
      chk("rf_reg", 32'(rf_reg), 32'(hd.r));
      chk("rf_data", rf_data, hd.d);
      chk("hit1", 32'(hit1), 32'(l1[32]));
      chk("fwd1", fwd_data1, l1[31:0]);
      chk("hit2", 32'(hit2), 32'(l2[32]));
      chk("fwd2", fwd_data2, l2[31:0]);
      if (rf_we) begin
         if (sb.size() == 0) begin
            n_chk++;
            $display("FAIL sb_underflow: got rf_we=1 want no write");
         end else begin
            e = sb.pop_front();
            chk("drain_reg", 32'(rf_reg), 32'(e.r));
            chk("drain_data", rf_data, e.d);
         end
      end
   end

   task automatic drive(input logic v, input logic [4:0] r,
                        input logic [31:0] d, input logic s,
                        input logic [4:0] a, input logic [4:0] b);
      wb_valid    = v;
      wb_reg      = r;
      wb_data     = d;
      rf_stall    = s;
      lookup_reg1 = a;
      lookup_reg2 = b;
   endtask

   task automatic tick();
      @(negedge clk);
      #1;
      model_step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_zero(input string nm);
      chk({nm, "_count"}, 32'(count), 32'd0);
      chk({nm, "_we"}, 32'(rf_we), 32'd0);
      chk({nm, "_reg"}, 32'(rf_reg), 32'd0);
      chk({nm, "_data"}, rf_data, 32'd0);
      chk({nm, "_hit1"}, 32'(hit1), 32'd0);
      chk({nm, "_hit2"}, 32'(hit2), 32'd0);
      chk({nm, "_fwd1"}, fwd_data1, 32'd0);
      chk({nm, "_fwd2"}, fwd_data2, 32'd0);
      chk({nm, "_ready"}, 32'(wb_ready), 32'd0);
   endtask

   task automatic release_reset();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      #1;
      chk("ready_after_rst", 32'(wb_ready), 32'd1);
   endtask

   initial begin
      rst_n = 1'b1;
      drive(0, 0, 0, 0, 1, 2);
      #2;
      rst_n = 1'b0;
      #1;
      chk_zero("rst");
      release_reset();

      // Single write and one-cycle drain latency.
      drive(1, 5'd2, 32'h0000F0F0, 0, 0, 0);
      tick();
      chk("single_we", 32'(rf_we), 32'd1);
      chk("single_reg", 32'(rf_reg), 32'd2);
      chk("single_data", rf_data, 32'h0000F0F0);
      drive(0, 0, 0, 0, 0, 0);
      tick();
      chk("single_cnt", 32'(count), 32'd0);

      // Fill while stalled, then drain in order.
      for (int i = 1; i <= 4; i++) begin
         drive(1, 5'(i), 32'(i * 11), 1, 5'(i), 0);
         tick();
      end
      drive(1, 5'd5, 32'd55, 1, 1, 4);
      #1;
      chk("full_ready", 32'(wb_ready), 32'd0);
      chk("full_cnt", 32'(count), 32'd4);
      tick();
      drive(0, 0, 0, 0, 0, 0);
      for (int i = 0; i < 5; i++) tick();

      // Forwarding of the youngest value.
      drive(1, 5'd7, 32'h0000AAAA, 1, 0, 0);
      tick();
      drive(1, 5'd7, 32'h0000BBBB, 1, 0, 0);
      tick();
      drive(0, 0, 0, 1, 5'd7, 5'd8);
      #1;
      chk("fwd_hit1", 32'(hit1), 32'd1);
      chk("fwd_data1", fwd_data1, 32'h0000BBBB);
      chk("fwd_hit2", 32'(hit2), 32'd0);
      chk("fwd_data2", fwd_data2, 32'd0);
      tick();
      drive(0, 0, 0, 0, 5'd7, 0);
      for (int i = 0; i < 3; i++) tick();

      // Writes to x0 are swallowed.
      drive(1, 5'd0, 32'h0000FFFF, 0, 0, 0);
      #1;
      chk("x0_ready", 32'(wb_ready), 32'd1);
      tick();
      chk("x0_cnt", 32'(count), 32'd0);
      chk("x0_we", 32'(rf_we), 32'd0);
      chk("x0_hit", 32'(hit1), 32'd0);

      // Back-to-back stream wrapping the pointers.
      for (int i = 1; i <= 10; i++) begin
         drive(1, 5'(i), 32'(32'h100 + i), 0, 5'(i), 0);
         tick();
      end
      drive(0, 0, 0, 0, 0, 0);
      tick();
      tick();

      // Asynchronous reset with entries pending.
      for (int i = 1; i <= 3; i++) begin
         drive(1, 5'(i + 20), 32'(i), 1, 5'd21, 5'd23);
         tick();
      end
      drive(0, 0, 0, 0, 5'd21, 5'd23);
      #1;
      rst_n = 1'b0;
      mq.delete();
      sb.delete();
      #1;
      chk_zero("mid_rst");
      @(posedge clk);
      release_reset();
      for (int i = 0; i < 4; i++) tick();

      // Random traffic, light then heavy stall.
      for (int ph = 0; ph < 2; ph++) begin
         for (int i = 0; i < 300; i++) begin
            drive($urandom_range(0, 3) != 0,
                  5'($urandom_range(0, 7)),
                  $urandom,
                  ph == 0 ? $urandom_range(0, 3) == 0
                          : $urandom_range(0, 3) != 0,
                  5'($urandom_range(0, 7)),
                  5'($urandom_range(0, 7)));
            tick();
         end
      end

      // Bounded drain.
      drive(0, 0, 0, 0, 0, 0);
      for (int i = 0; i < 20 && mq.size() > 0; i++) tick();
      tick();
      chk("final_empty", 32'(count), 32'd0);
      chk("sb_empty", 32'(sb.size()), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/writeback_queue.md
WRITEBACK_QUEUE -- requirements
Module: writeback_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, queue entry count; legal values 2, 4, 8.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port wb_valid  input  1  producer offers a register write.
REQ-005 SHALL have port wb_ready  output  1  queue can accept a write this cycle.
REQ-006 SHALL have port wb_reg  input  5  destination register index.
REQ-007 SHALL have port wb_data  input  32  write value.
REQ-008 SHALL have port rf_stall  input  1  register file write port unavailable this cycle.
REQ-009 SHALL have port rf_we  output  1  write strobe to register file.
REQ-010 SHALL have port rf_reg  output  5  register file write index.
REQ-011 SHALL have port rf_data  output  32  register file write data.
REQ-012 SHALL have ports lookup_reg1, lookup_reg2  input  5 each  read indices to check for pending writes.
REQ-013 SHALL have ports hit1, hit2  output  1 each  pending write exists for the lookup index.
REQ-014 SHALL have ports fwd_data1, fwd_data2  output  32 each  youngest pending value for the lookup index.
REQ-015 SHALL have port count  output  clog2(DEPTH)+1  number of occupied entries.

Function
REQ-016 Circular FIFO of DEPTH entries {reg[4:0], data[31:0]}, write pointer, read pointer, occupancy counter.
REQ-017 wb_ready SHALL be combinational: 1 iff count < DEPTH and rst_n high.
REQ-018 Accept: wb_valid && wb_ready at a rising edge; entry stored at write pointer, pointer advances mod DEPTH.
REQ-019 Accepted write with wb_reg == 0 SHALL complete the handshake but store no entry (count unchanged).
REQ-020 rf_we SHALL be combinational: 1 iff count > 0 and rf_stall == 0; rf_reg/rf_data SHALL show the head entry, rf_data 0 and rf_reg 0 when empty.
REQ-021 Drain: when rf_we == 1 at a rising edge, head is popped, read pointer advances mod DEPTH; at most one pop per cycle.
REQ-022 Latency: write accepted into empty queue at edge N, rf_stall low -> rf_we high during cycle N..N+1, popped at edge N+1.
REQ-023 Simultaneous accept and pop in one edge: count unchanged, both pointers advance.
REQ-024 Full queue (count == DEPTH): wb_ready 0 even if a pop occurs that edge (no same-cycle reuse of freed slot).
REQ-025 rf_stall high: no pop, rf_we 0, entries held indefinitely; accepts continue until full.
REQ-026 Order: entries SHALL reach rf_* strictly in acceptance order; repeated writes to one index are all emitted.
REQ-027 Lookup (combinational, per port): scan occupied entries; hit = 1 if any entry.reg == lookup_reg; fwd_data = data of youngest matching entry; hit 0, fwd_data 0 when no match or lookup_reg == 0.
REQ-028 Lookup SHALL include the head entry even while it is on rf_* this cycle; it SHALL NOT include the wb_* input of the current cycle.
REQ-029 Pointer wrap: read and write pointers SHALL wrap from DEPTH-1 to 0 with no loss or duplication.

Reset
REQ-030 rst_n low SHALL immediately clear count, both pointers: count 0, rf_we 0, rf_reg 0, rf_data 0, hit1/hit2 0, fwd_data1/2 0, wb_ready 0.
REQ-031 Reset mid-operation SHALL discard all pending entries; no rf_we pulse after reset for pre-reset data.
REQ-032 First rising edge with rst_n high SHALL be able to accept a write (wb_ready 1).

Verification
REQ-033 Single write: reset, wb_valid=1 wb_reg=2 wb_data=0000F0F0 for one edge -> next cycle rf_we=1 rf_reg=2 rf_data=0000F0F0, then count 0.
REQ-034 Fill/stall: rf_stall=1, push regs 1,2,3,4 (data 11,22,33,44), then 5th offer -> wb_ready 0 at count 4; release stall -> rf_* emits 1,2,3,4 in four consecutive cycles.
REQ-035 Forwarding: rf_stall=1, push reg 7=AAAA then reg 7=BBBB; lookup_reg1=7 -> hit1=1 fwd_data1=0000BBBB; lookup_reg2=8 -> hit2=0 fwd_data2=0.
REQ-036 Zero register: push reg 0=FFFF -> handshake completes, count stays 0, rf_we stays 0, lookup_reg1=0 -> hit1=0.
REQ-037 Wrap and concurrency: stream 10 writes back-to-back with rf_stall low -> every write emitted in order, count never exceeds 1, pointers wrap twice.
REQ-038 Reset mid-stream: rf_stall=1, push 3 entries, drop rst_n asynchronously between edges -> count 0, rf_we 0 immediately; after release no stale writes emitted.
